corner_writeback: RTL and testbench

CORNER_WRITEBACK -- requirements
Module: corner_writeback

---
 rtl/flip_pkg.sv | 20 ++
 rtl/corner_addr_gen.sv | 19 +
 rtl/corner_writeback.sv | 162 ++++++++++++++++
 tb/tb_corner_writeback.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/flip_pkg.sv
// Shared definitions for the corner flip datapath (flip_controller reads corners,
// corner_writeback writes them back).
package flip_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] C00 = 2'd0;
    localparam logic [1:0] C01 = 2'd1;
    localparam logic [1:0] C10 = 2'd2;
    localparam logic [1:0] C11 = 2'd3;

    localparam int DEFAULT_ROWS       = 4;
    localparam int DEFAULT_COLS       = 4;
    localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/corner_addr_gen.sv
// Combinational row-major address of one matrix element, wrapping modulo 2^ADDR_WIDTH.
module corner_addr_gen #(
    parameter int ADDR_WIDTH = 8,
    parameter int COLS       = 4,
    parameter int ROW_WIDTH  = 2,
    parameter int COL_WIDTH  = 2
) (
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ROW_WIDTH-1:0]  row,
    input  logic [COL_WIDTH-1:0]  col,
    output logic [ADDR_WIDTH-1:0] addr
);

    logic [ADDR_WIDTH-1:0] row_offset;

    assign row_offset = ADDR_WIDTH'(row) * ADDR_WIDTH'(COLS);
    assign addr       = base + row_offset + ADDR_WIDTH'(col);

endmodule

// File: rtl/corner_writeback.sv
// Writes the four (possibly coincident) rectangle corners back to matrix memory,
// one acknowledged write at a time, with a per-write ack timeout.
module corner_writeback
    import flip_pkg::*;
#(
    parameter int ROWS        = DEFAULT_ROWS,
    parameter int COLS        = DEFAULT_COLS,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 16,
    localparam int ROW_WIDTH  = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int COL_WIDTH  = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [ROW_WIDTH-1:0]    r1,
    input  logic [ROW_WIDTH-1:0]    r2,
    input  logic [COL_WIDTH-1:0]    c1,
    input  logic [COL_WIDTH-1:0]    c2,
    input  logic [4*DATA_WIDTH-1:0] corner_data,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ack,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int WAIT_WIDTH = $clog2(ACK_TIMEOUT + 1);

    state_t                  state_reg, state_next;
    logic [1:0]              idx_reg, idx_next;
    logic [WAIT_WIDTH-1:0]   wait_reg, wait_next;
    logic                    err_reg, err_next;
    logic                    latch_req;

    logic [ADDR_WIDTH-1:0]   base_reg;
    logic [ROW_WIDTH-1:0]    r1_reg, r2_reg;
    logic [COL_WIDTH-1:0]    c1_reg, c2_reg;
    logic [4*DATA_WIDTH-1:0] data_reg;

    logic [3:0][ADDR_WIDTH-1:0] corner_addr;
    logic [3:0]                 corner_valid;
    logic                       has_next;
    logic [1:0]                 next_idx;

    // Corner gi uses r2 for the lower pair and c2 for the odd corners.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_corner
            corner_addr_gen #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .COLS       (COLS),
                .ROW_WIDTH  (ROW_WIDTH),
                .COL_WIDTH  (COL_WIDTH)
            ) u_addr (
                .base (base_reg),
                .row  ((gi >= 2) ? r2_reg : r1_reg),
                .col  ((gi % 2 == 1) ? c2_reg : c1_reg),
                .addr (corner_addr[gi])
            );
        end
    endgenerate

    always_comb begin
        corner_valid      = '0;
        corner_valid[C00] = 1'b1;
        corner_valid[C01] = (c1_reg != c2_reg);
        corner_valid[C10] = (r1_reg != r2_reg);
        corner_valid[C11] = (c1_reg != c2_reg) && (r1_reg != r2_reg);
    end

    // Lowest-numbered valid corner after the current one; descending scan so it wins.
    always_comb begin
        has_next = 1'b0;
        next_idx = idx_reg;
        for (int i = 3; i >= 0; i--) begin
            if (2'(i) > idx_reg && corner_valid[i]) begin
                has_next = 1'b1;
                next_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        wait_next  = wait_reg;
        err_next   = err_reg;
        latch_req  = 1'b0;
        case (state_reg)
            IDLE: begin
                idx_next  = C00;
                wait_next = '0;
                err_next  = 1'b0;
                if (start) begin
                    latch_req  = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    wait_next = '0;
                    if (has_next) begin
                        idx_next = next_idx;
                    end else begin
                        state_next = DONE;
                    end
                end else if (wait_reg == WAIT_WIDTH'(ACK_TIMEOUT - 1)) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            wait_reg  <= '0;
            err_reg   <= 1'b0;
            base_reg  <= '0;
            r1_reg    <= '0;
            r2_reg    <= '0;
            c1_reg    <= '0;
            c2_reg    <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            wait_reg  <= wait_next;
            err_reg   <= err_next;
            if (latch_req) begin
                base_reg <= base_addr;
                r1_reg   <= r1;
                r2_reg   <= r2;
                c1_reg   <= c1;
                c2_reg   <= c2;
                data_reg <= corner_data;
            end
        end
    end

    assign mem_we    = (state_reg == WRITE);
    assign busy      = (state_reg == WRITE);
    assign done      = (state_reg == DONE);
    assign err       = (state_reg == DONE) && err_reg;
    assign mem_addr  = mem_we ? corner_addr[idx_reg] : '0;
    assign mem_wdata = mem_we ? data_reg[idx_reg*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_corner_writeback.sv
// Directed self-checking bench for corner_writeback: one task per scenario,
// cycle numbers counted from the edge that samples start (cycle 0).
module tb_corner_writeback;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [1:0]  r1 = '0, r2 = '0, c1 = '0, c2 = '0;
    logic [31:0] corner_data = '0;
    logic        mem_we;
    logic [7:0]  mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic        busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] wr_addr [8];
    logic [7:0] wr_data [8];
    int         wr_cyc  [8];
    int         n_wr, done_cyc, done_cnt, we_cnt, busy_bad, unstable, err_stray;
    logic       err_at_done;
    logic [7:0] first_we_addr;

    corner_writeback dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .r1          (r1),
        .r2          (r2),
        .c1          (c1),
        .c2          (c2),
        .corner_data (corner_data),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Issues one request and logs the bus for max_cyc cycles. ack_mode: 0 = tied high,
    // <0 = never, n>0 = ack after n wait cycles per write. Caller must be at a negedge.
    task automatic run_op(input logic [7:0] b, input logic [1:0] a1, input logic [1:0] a2,
                          input logic [1:0] b1, input logic [1:0] b2, input logic [31:0] d,
                          input int ack_mode, input int max_cyc, input int restart_cyc);
        int         hold = 0;
        logic       prev_pend = 1'b0;
        logic       first = 1'b1;
        logic [7:0] prev_a = '0, prev_d = '0;
        n_wr = 0; done_cyc = -1; done_cnt = 0; we_cnt = 0; busy_bad = 0;
        unstable = 0; err_stray = 0; err_at_done = 1'b0; first_we_addr = '0;
        base_addr = b; r1 = a1; r2 = a2; c1 = b1; c2 = b2; corner_data = d;
        start = 1'b1;
        mem_ack = (ack_mode == 0);
        @(posedge clk);
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            start = (c == restart_cyc);
            if (c == restart_cyc) base_addr = 8'h80;
            if (busy !== mem_we) busy_bad++;
            if (err === 1'b1 && done !== 1'b1) err_stray++;
            if (done === 1'b1) begin
                done_cnt++; done_cyc = c; err_at_done = err;
            end
            if (prev_pend && (mem_we !== 1'b1 || mem_addr !== prev_a || mem_wdata !== prev_d)
                && !(done === 1'b1 && err === 1'b1)) unstable++;
            if (mem_we === 1'b1) begin
                we_cnt++;
                if (first) begin first_we_addr = mem_addr; first = 1'b0; end
            end
            if (ack_mode == 0) mem_ack = 1'b1;
            else if (ack_mode < 0) mem_ack = 1'b0;
            else if (mem_we === 1'b1) begin
                mem_ack = (hold == ack_mode);
                hold = (hold == ack_mode) ? 0 : hold + 1;
            end else begin
                mem_ack = 1'b0; hold = 0;
            end
            if (mem_we === 1'b1 && mem_ack) begin
                if (n_wr < 8) begin
                    wr_addr[n_wr] = mem_addr; wr_data[n_wr] = mem_wdata; wr_cyc[n_wr] = c;
                end
                n_wr++;
            end
            prev_pend = (mem_we === 1'b1) && !mem_ack;
            prev_a = mem_addr; prev_d = mem_wdata;
        end
        start = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; base_addr = 8'h33; r1 = 2'd1; c2 = 2'd2; mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", mem_we); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", mem_addr); end
        n_checks++; if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %h expected 00", mem_wdata); end
        $display("reset: we=%b busy=%b done=%b err=%b addr=%h", mem_we, busy, done, err, mem_addr);
        start = 1'b0; mem_ack = 1'b0; base_addr = '0; r1 = '0; c2 = '0;
        reset = 1'b0;
    endtask

    task automatic check_full_seq(input string tag, input int exp_done);
        logic [7:0] ea [4] = '{8'd5, 8'd6, 8'd13, 8'd14};
        logic [7:0] ed [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        n_checks++; if (n_wr !== 4) begin n_fail++; $display("FAIL %s_count: got %0d expected 4", tag, n_wr); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i]) begin
                n_fail++;
                $display("FAIL %s_write%0d: got (%h,%h) expected (%h,%h)", tag, i, wr_addr[i], wr_data[i], ea[i], ed[i]);
            end
        end
        n_checks++; if (done_cyc !== exp_done) begin n_fail++; $display("FAIL %s_done_cycle: got %0d expected %0d", tag, done_cyc, exp_done); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL %s_done_pulses: got %0d expected 1", tag, done_cnt); end
        n_checks++; if (err_at_done !== 1'b0) begin n_fail++; $display("FAIL %s_err: got %b expected 0", tag, err_at_done); end
        n_checks++; if (busy_bad !== 0) begin n_fail++; $display("FAIL %s_busy: got %0d bad cycles expected 0", tag, busy_bad); end
        $display("%s: writes=%0d done_cycle=%0d err=%b", tag, n_wr, done_cyc, err_at_done);
    endtask

    task automatic test_full_zero_wait();
        run_op(8'h00, 2'd1, 2'd3, 2'd1, 2'd2, 32'h44332211, 0, 8, 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (wr_cyc[i] !== i + 1) begin n_fail++; $display("FAIL zw_cycle%0d: got %0d expected %0d", i, wr_cyc[i], i + 1); end
        end
        check_full_seq("zero_wait", 5);
    endtask

    task automatic test_ack_delay();
        run_op(8'h00, 2'd1, 2'd3, 2'd1, 2'd2, 32'h44332211, 3, 22, 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (wr_cyc[i] !== 4 * (i + 1)) begin n_fail++; $display("FAIL delay_cycle%0d: got %0d expected %0d", i, wr_cyc[i], 4 * (i + 1)); end
        end
        n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL delay_stable: got %0d changes expected 0", unstable); end
        n_checks++; if (we_cnt !== 16) begin n_fail++; $display("FAIL delay_we_cycles: got %0d expected 16", we_cnt); end
        check_full_seq("ack_delay", 17);
    endtask

    task automatic test_duplicates();
        // r1==r2 with wrap-around
        run_op(8'hFE, 2'd3, 2'd3, 2'd0, 2'd3, 32'hD4C3B2A1, 0, 6, 0);
        n_checks++; if (n_wr !== 2) begin n_fail++; $display("FAIL rowdup_count: got %0d expected 2", n_wr); end
        n_checks++; if (wr_addr[0] !== 8'h0A || wr_data[0] !== 8'hA1) begin n_fail++; $display("FAIL rowdup_w0: got (%h,%h) expected (0a,a1)", wr_addr[0], wr_data[0]); end
        n_checks++; if (wr_addr[1] !== 8'h0D || wr_data[1] !== 8'hB2) begin n_fail++; $display("FAIL rowdup_w1: got (%h,%h) expected (0d,b2)", wr_addr[1], wr_data[1]); end
        n_checks++; if (done_cyc !== 3) begin n_fail++; $display("FAIL rowdup_done: got %0d expected 3", done_cyc); end
        $display("row_dup: writes=%0d done_cycle=%0d", n_wr, done_cyc);
        // c1==c2 keeps corners 0 and 2
        run_op(8'h10, 2'd0, 2'd2, 2'd1, 2'd1, 32'hD4C3B2A1, 0, 6, 0);
        n_checks++; if (n_wr !== 2) begin n_fail++; $display("FAIL coldup_count: got %0d expected 2", n_wr); end
        n_checks++; if (wr_addr[0] !== 8'h11 || wr_data[0] !== 8'hA1) begin n_fail++; $display("FAIL coldup_w0: got (%h,%h) expected (11,a1)", wr_addr[0], wr_data[0]); end
        n_checks++; if (wr_addr[1] !== 8'h19 || wr_data[1] !== 8'hC3) begin n_fail++; $display("FAIL coldup_w1: got (%h,%h) expected (19,c3)", wr_addr[1], wr_data[1]); end
        n_checks++; if (done_cyc !== 3) begin n_fail++; $display("FAIL coldup_done: got %0d expected 3", done_cyc); end
        $display("col_dup: writes=%0d done_cycle=%0d", n_wr, done_cyc);
        // both equal: a single write
        run_op(8'h03, 2'd2, 2'd2, 2'd1, 2'd1, 32'hD4C3B2A1, 0, 5, 0);
        n_checks++; if (n_wr !== 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", n_wr); end
        n_checks++; if (wr_addr[0] !== 8'h0C || wr_data[0] !== 8'hA1) begin n_fail++; $display("FAIL single_w0: got (%h,%h) expected (0c,a1)", wr_addr[0], wr_data[0]); end
        n_checks++; if (done_cyc !== 2) begin n_fail++; $display("FAIL single_done: got %0d expected 2", done_cyc); end
        $display("single: writes=%0d done_cycle=%0d", n_wr, done_cyc);
    endtask

    task automatic test_timeout();
        run_op(8'h00, 2'd1, 2'd3, 2'd1, 2'd2, 32'h44332211, -1, 22, 0);
        n_checks++; if (n_wr !== 0) begin n_fail++; $display("FAIL to_acked: got %0d expected 0", n_wr); end
        n_checks++; if (we_cnt !== 16) begin n_fail++; $display("FAIL to_we_cycles: got %0d expected 16", we_cnt); end
        n_checks++; if (first_we_addr !== 8'd5) begin n_fail++; $display("FAIL to_addr: got %h expected 05", first_we_addr); end
        n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL to_stable: got %0d changes expected 0", unstable); end
        n_checks++; if (done_cyc !== 17) begin n_fail++; $display("FAIL to_done: got %0d expected 17", done_cyc); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL to_done_pulses: got %0d expected 1", done_cnt); end
        n_checks++; if (err_at_done !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b expected 1", err_at_done); end
        n_checks++; if (err_stray !== 0) begin n_fail++; $display("FAIL to_err_stray: got %0d expected 0", err_stray); end
        $display("timeout: we_cycles=%0d done_cycle=%0d err=%b", we_cnt, done_cyc, err_at_done);
    endtask

    task automatic test_reset_mid();
        base_addr = 8'h00; r1 = 2'd1; r2 = 2'd3; c1 = 2'd1; c2 = 2'd2; corner_data = 32'h44332211;
        start = 1'b1; mem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (mem_we !== 1'b1 || mem_addr !== 8'd5) begin n_fail++; $display("FAIL rm_first: got we=%b addr=%h expected we=1 addr=05", mem_we, mem_addr); end
        @(negedge clk);
        n_checks++; if (mem_we !== 1'b1 || mem_addr !== 8'd6) begin n_fail++; $display("FAIL rm_second: got we=%b addr=%h expected we=1 addr=06", mem_we, mem_addr); end
        reset = 1'b1;
        #1;
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rm_we_drop: got %b expected 0", mem_we); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy_drop: got %b expected 0", busy); end
        n_checks++; if (mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin n_fail++; $display("FAIL rm_bus_zero: got (%h,%h) expected (00,00)", mem_addr, mem_wdata); end
        @(negedge clk);
        n_checks++; if (mem_we !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rm_held: got we=%b done=%b expected 0 0", mem_we, done); end
        $display("reset_mid: we=%b busy=%b after reset", mem_we, busy);
        reset = 1'b0;
        run_op(8'h00, 2'd1, 2'd3, 2'd1, 2'd2, 32'h44332211, 0, 8, 0);
        check_full_seq("after_reset", 5);
    endtask

    task automatic test_start_ignored();
        run_op(8'h00, 2'd1, 2'd3, 2'd1, 2'd2, 32'h44332211, 0, 10, 2);
        check_full_seq("start_ignored", 5);
    endtask

    initial begin
        test_reset();
        test_full_zero_wait();
        test_ack_delay();
        test_duplicates();
        test_timeout();
        test_start_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
